sr_flag_arbiter: RTL

- Shared bank of NFLAG SR status flags, written by NREQ independent requesters.
- Each requester issues {s,r} commands to a flag address through a req/gnt handshake.
- A round-robin arbiter serialises commands: at most one flag update per cycle.
- Sits between control agents (sequencers, interrupt sources) and the SR-flag storage; owns conflict resolution and invalid-command detection.

---
 rtl/sr_flag_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbitrated bank of SR flags with sticky invalid-command error.
// Optional saturating error counter on port err_cnt when SR_ERR_CNT_EN is defined.
module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   s,
  input  logic [NREQ-1:0]   r,
  input  logic [NREQ*AW-1:0] addr,
  input  logic              err_clr,
  output logic [NREQ-1:0]   gnt,
  output logic [NFLAG-1:0]  q,
  output logic [NFLAG-1:0]  q_bar,
  output logic              err,
  output logic [AW-1:0]     err_id
`ifdef SR_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, COMMIT} state_e;

  state_e            state_q;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     w_q;
  logic [1:0]        cmd_q;
  logic [AW-1:0]     ca_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NFLAG-1:0]  q_q;
  logic              err_q;
  logic [AW-1:0]     err_id_q;
`ifdef SR_ERR_CNT_EN
  logic [7:0]        cnt_q;
`endif

  logic              any_req;
  logic [PW-1:0]     win;

  // Scan downward so the requester closest to the pointer is kept.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req[(int'(ptr_q) + k) % NREQ]) begin
        any_req = 1'b1;
        win     = PW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      w_q      <= '0;
      cmd_q    <= '0;
      ca_q     <= '0;
      gnt_q    <= '0;
      q_q      <= '0;
      err_q    <= 1'b0;
      err_id_q <= '0;
`ifdef SR_ERR_CNT_EN
      cnt_q    <= '0;
`endif
    end else begin
      gnt_q <= '0;
      if (err_clr) begin
        err_q    <= 1'b0;
        err_id_q <= '0;
`ifdef SR_ERR_CNT_EN
        cnt_q    <= '0;
`endif
      end
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            w_q     <= win;
            cmd_q   <= {s[win], r[win]};
            ca_q    <= addr[int'(win)*AW +: AW];
            gnt_q   <= NREQ'(1) << win;
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          ptr_q   <= (w_q == PW'(NREQ-1)) ? '0 : w_q + 1'b1;
          // Out-of-range addresses are granted but discarded.
          if (int'(ca_q) < NFLAG) begin
            unique case (cmd_q)
              2'b00: ;
              2'b01: q_q[ca_q] <= 1'b0;
              2'b10: q_q[ca_q] <= 1'b1;
              2'b11: begin
                q_q[ca_q] <= 1'b0;
                err_q     <= 1'b1;
                if (!err_q || err_clr) err_id_q <= ca_q;
`ifdef SR_ERR_CNT_EN
                if (err_clr)
                  cnt_q <= 8'd1;
                else if (cnt_q != 8'hFF)
                  cnt_q <= cnt_q + 8'd1;
`endif
              end
            endcase
          end
        end
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign q      = q_q;
  assign q_bar  = ~q_q;
  assign err    = err_q;
  assign err_id = err_id_q;
`ifdef SR_ERR_CNT_EN
  assign err_cnt = cnt_q;
`endif

endmodule
